// File: rtl/hicore_commit_pkg.sv
// Shared definitions for the commit stage: HiCore_* width defines, the
// commit_info field layout and the commit FSM state encodings.
// Optional feature macro used elsewhere: HICORE_COMMIT_INSTRET_EN.
`ifndef HiCore_RFIDX_WIDTH
`define HiCore_RFIDX_WIDTH 5
`endif
`ifndef HiCore_CSRIDX_WIDTH
`define HiCore_CSRIDX_WIDTH 12
`endif
`ifndef HiCore_REG_SIZE
`define HiCore_REG_SIZE 32
`endif
`ifndef HiCore_PC_SIZE
`define HiCore_PC_SIZE 32
`endif
`ifndef HiCore_WB_SIZE
`define HiCore_WB_SIZE (6 + `HiCore_PC_SIZE)
`endif

package hicore_commit_pkg;
    localparam int RFIDX_W  = `HiCore_RFIDX_WIDTH;
    localparam int CSRIDX_W = `HiCore_CSRIDX_WIDTH;
    localparam int REG_W    = `HiCore_REG_SIZE;
    localparam int PC_W     = `HiCore_PC_SIZE;
    localparam int WB_W     = `HiCore_WB_SIZE;

    // commit_info layout
    localparam int WB_REDIRECT  = 0;
    localparam int WB_EXC       = 1;
    localparam int WB_CAUSE_LSB = 2;
    localparam int WB_CAUSE_W   = 4;
    localparam int WB_EPC_LSB   = 6;

    typedef enum logic [1:0] {
        ST_RUN         = 2'b00,
        ST_FENCEI_WAIT = 2'b01,
        ST_REDIR       = 2'b10
    } commit_state_e;
endpackage

// File: rtl/gnrl_dfflr.sv
// Generic load-enabled flop with asynchronous active-low reset to zero.
module gnrl_dfflr #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);
    // Load on enable, clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    qout <= '0;
        else if (lden) qout <= dnxt;
    end
endmodule

// File: rtl/hicore_commit_fsm.sv
// Commit sequencing FSM: holds the retire state, the post-fence.i resume
// PC and the I-cache invalidate handshake.
//   state          | meaning
//   ST_RUN         | retiring, commit_valid asserted
//   ST_FENCEI_WAIT | fence.i retired, waiting for I-cache invalidate ack
//   ST_REDIR       | one cycle redirect of fetch to pc_q
module hicore_commit_fsm
    import hicore_commit_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fencei_go,
    input  logic [PC_W-1:0] next_pc,
    input  logic            icache_inv_ack,
    output logic            commit_valid,
    output logic            icache_inv_req,
    output logic            redir_valid,
    output logic [PC_W-1:0] pc_q
);
    commit_state_e state, state_nxt;
    logic [1:0]    state_q;

    // State register; ST_RUN encodes as zero so reset lands in RUN.
    gnrl_dfflr #(.DW(2)) u_state (
        .clk(clk), .rst_n(rst_n), .lden(1'b1),
        .dnxt(state_nxt), .qout(state_q)
    );
    assign state = commit_state_e'(state_q);

    // Resume PC captured at the fence.i retire.
    gnrl_dfflr #(.DW(PC_W)) u_pc (
        .clk(clk), .rst_n(rst_n), .lden(fencei_go),
        .dnxt(next_pc), .qout(pc_q)
    );

    // Next-state decode; an ack outside FENCEI_WAIT has no effect.
    always_comb begin
        state_nxt = ST_RUN;
        case (state)
            ST_RUN:         state_nxt = fencei_go ? ST_FENCEI_WAIT : ST_RUN;
            ST_FENCEI_WAIT: state_nxt = icache_inv_ack ? ST_REDIR : ST_FENCEI_WAIT;
            ST_REDIR:       state_nxt = ST_RUN;
            default:        state_nxt = ST_RUN;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        commit_valid   = (state == ST_RUN);
        icache_inv_req = (state == ST_FENCEI_WAIT);
        redir_valid    = (state == ST_REDIR);
    end
endmodule

// File: rtl/hicore_commit.sv
// In-order retirement unit: retire decode, architectural write muxing,
// flush/redirect/trap generation. Sequencing lives in hicore_commit_fsm.
// Optional: HICORE_COMMIT_INSTRET_EN adds a 64-bit instret counter/port.
module hicore_commit
    import hicore_commit_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    output logic                commit_valid,
    input  logic                commit_ready,
    input  logic                commit_rd_need,
    input  logic [RFIDX_W-1:0]  commit_rd_idx,
    input  logic [REG_W-1:0]    commit_rd_data,
    input  logic                commit_csr_need,
    input  logic [CSRIDX_W-1:0] commit_csr_idx,
    input  logic [REG_W-1:0]    commit_csr_data,
    input  logic                commit_fence_i_op,
    input  logic                commit_mret_op,
    input  logic [PC_W-1:0]     commit_next_pc,
    input  logic [WB_W-1:0]     commit_info,
    output logic                flush,
    output logic                rf_wen,
    output logic [RFIDX_W-1:0]  rf_waddr,
    output logic [REG_W-1:0]    rf_wdata,
    output logic                csr_wen,
    output logic [CSRIDX_W-1:0] csr_waddr,
    output logic [REG_W-1:0]    csr_wdata,
    output logic                trap_valid,
    output logic [PC_W-1:0]     trap_epc,
    output logic [3:0]          trap_cause,
    input  logic [PC_W-1:0]     csr_mtvec,
    input  logic [PC_W-1:0]     csr_mepc,
    output logic                icache_inv_req,
    input  logic                icache_inv_ack,
    output logic                redirect_valid,
    output logic [PC_W-1:0]     redirect_pc
`ifdef HICORE_COMMIT_INSTRET_EN
    ,
    output logic [63:0]         instret
`endif
);
    logic            retire, exc, mispred, fencei_go, fsm_redir;
    logic [PC_W-1:0] pc_q;

    // rst_n gates the handshake so every output except commit_valid is
    // quiet while reset is held, even if the ROB presents a ready head.
    assign retire    = commit_valid & commit_ready & rst_n;
    assign exc       = commit_info[WB_EXC];
    assign mispred   = commit_info[WB_REDIRECT];
    assign fencei_go = retire & commit_fence_i_op & ~exc;

    hicore_commit_fsm u_fsm (
        .clk(clk), .rst_n(rst_n), .fencei_go(fencei_go),
        .next_pc(commit_next_pc), .icache_inv_ack(icache_inv_ack),
        .commit_valid(commit_valid), .icache_inv_req(icache_inv_req),
        .redir_valid(fsm_redir), .pc_q(pc_q)
    );

    // Architectural writes; an excepting head writes nothing.
    always_comb begin
        rf_wen    = retire & commit_rd_need & (|commit_rd_idx) & ~exc;
        csr_wen   = retire & commit_csr_need & ~exc;
        rf_waddr  = rst_n ? commit_rd_idx   : '0;
        rf_wdata  = rst_n ? commit_rd_data  : '0;
        csr_waddr = rst_n ? commit_csr_idx  : '0;
        csr_wdata = rst_n ? commit_csr_data : '0;
    end

    // Exception report to the CSR file.
    always_comb begin
        trap_valid = retire & exc;
        trap_epc   = trap_valid ? commit_info[WB_EPC_LSB +: PC_W] : '0;
        trap_cause = trap_valid ? commit_info[WB_CAUSE_LSB +: WB_CAUSE_W] : '0;
    end

    // Flush and fetch redirect, priority exc > fence.i > mret > mispredict.
    // fence.i defers its redirect to the REDIR state.
    always_comb begin
        flush          = retire & (exc | commit_fence_i_op | commit_mret_op | mispred);
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if (fsm_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = pc_q;
        end else if (retire) begin
            if (exc) begin
                redirect_valid = 1'b1;
                redirect_pc    = csr_mtvec;
            end else if (commit_fence_i_op) begin
                redirect_valid = 1'b0;
            end else if (commit_mret_op) begin
                redirect_valid = 1'b1;
                redirect_pc    = csr_mepc;
            end else if (mispred) begin
                redirect_valid = 1'b1;
                redirect_pc    = commit_next_pc;
            end
        end
    end

`ifdef HICORE_COMMIT_INSTRET_EN
    // Retired-instruction counter; excepting retires are not counted.
    gnrl_dfflr #(.DW(64)) u_instret (
        .clk(clk), .rst_n(rst_n), .lden(retire & ~exc),
        .dnxt(instret + 64'd1), .qout(instret)
    );
`endif
endmodule

// File: tb/tb_hicore_commit.sv
// Directed bench for hicore_commit: vector table for single-cycle retires,
// hand sequences for fence.i, ack corner cases and reset in FENCEI_WAIT.
module tb_hicore_commit;
    import hicore_commit_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                commit_valid, commit_ready;
    logic                commit_rd_need;
    logic [RFIDX_W-1:0]  commit_rd_idx;
    logic [REG_W-1:0]    commit_rd_data;
    logic                commit_csr_need;
    logic [CSRIDX_W-1:0] commit_csr_idx;
    logic [REG_W-1:0]    commit_csr_data;
    logic                commit_fence_i_op, commit_mret_op;
    logic [PC_W-1:0]     commit_next_pc;
    logic [WB_W-1:0]     commit_info;
    logic                flush, rf_wen, csr_wen, trap_valid;
    logic [RFIDX_W-1:0]  rf_waddr;
    logic [REG_W-1:0]    rf_wdata, csr_wdata;
    logic [CSRIDX_W-1:0] csr_waddr;
    logic [PC_W-1:0]     trap_epc, csr_mtvec, csr_mepc, redirect_pc;
    logic [3:0]          trap_cause;
    logic                icache_inv_req, icache_inv_ack, redirect_valid;
`ifdef HICORE_COMMIT_INSTRET_EN
    logic [63:0]         instret;
    logic [63:0]         exp_instret;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hicore_commit dut (
        .clk(clk), .rst_n(rst_n),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_rd_need(commit_rd_need), .commit_rd_idx(commit_rd_idx),
        .commit_rd_data(commit_rd_data), .commit_csr_need(commit_csr_need),
        .commit_csr_idx(commit_csr_idx), .commit_csr_data(commit_csr_data),
        .commit_fence_i_op(commit_fence_i_op), .commit_mret_op(commit_mret_op),
        .commit_next_pc(commit_next_pc), .commit_info(commit_info),
        .flush(flush), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .trap_valid(trap_valid), .trap_epc(trap_epc), .trap_cause(trap_cause),
        .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
        .icache_inv_req(icache_inv_req), .icache_inv_ack(icache_inv_ack),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef HICORE_COMMIT_INSTRET_EN
        , .instret(instret)
`endif
    );

    typedef struct {
        logic                ready;
        logic                rd_need;
        logic [RFIDX_W-1:0]  rd_idx;
        logic [REG_W-1:0]    rd_data;
        logic                csr_need;
        logic [CSRIDX_W-1:0] csr_idx;
        logic [REG_W-1:0]    csr_data;
        logic                fence;
        logic                mret;
        logic [PC_W-1:0]     next_pc;
        logic [WB_W-1:0]     info;
        logic                e_flush;
        logic                e_rf_wen;
        logic                e_csr_wen;
        logic                e_trap;
        logic [PC_W-1:0]     e_trap_epc;
        logic [3:0]          e_trap_cause;
        logic                e_redir;
        logic [PC_W-1:0]     e_redir_pc;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    function automatic logic [WB_W-1:0] wb(input logic redir, input logic ex,
                                           input logic [3:0] cause, input logic [PC_W-1:0] epc);
        logic [WB_W-1:0] v;
        v = {epc, cause, ex, redir};
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        commit_ready = 0; commit_rd_need = 0; commit_rd_idx = '0; commit_rd_data = '0;
        commit_csr_need = 0; commit_csr_idx = '0; commit_csr_data = '0;
        commit_fence_i_op = 0; commit_mret_op = 0; commit_next_pc = '0;
        commit_info = '0; icache_inv_ack = 0;
        csr_mtvec = 32'h100; csr_mepc = 32'h300;
    endtask

    // fence.i retire followed by ack_delay FENCEI_WAIT cycles, then REDIR
    task automatic fence_seq(input logic [PC_W-1:0] pc, input int wait_cycles);
        @(negedge clk);
        idle();
        commit_ready = 1; commit_fence_i_op = 1; commit_next_pc = pc;
        commit_info = wb(1'b1, 1'b0, 4'd0, '0);
        #1;
        chk("fence_flush", flush, 1);
        chk("fence_no_redir", redirect_valid, 0);
`ifdef HICORE_COMMIT_INSTRET_EN
        exp_instret++;
`endif
        for (int k = 0; k < wait_cycles; k++) begin
            @(negedge clk);
            commit_fence_i_op = 0; commit_rd_need = 1; commit_rd_idx = 5'd9;
            icache_inv_ack = (k == wait_cycles - 1);
            #1;
            chk("fw_commit_valid", commit_valid, 0);
            chk("fw_inv_req", icache_inv_req, 1);
            chk("fw_rf_wen", rf_wen, 0);
        end
        @(negedge clk);
        idle();
        commit_ready = 1;
        #1;
        chk("redir_valid", redirect_valid, 1);
        chk("redir_pc", redirect_pc, pc);
        chk("redir_commit_valid", commit_valid, 0);
        chk("redir_inv_req", icache_inv_req, 0);
        @(negedge clk);
        idle();
        #1;
        chk("after_redir_commit_valid", commit_valid, 1);
        chk("after_redir_redir", redirect_valid, 0);
    endtask

    initial begin
        vecs[0] = '{1,1,5'd5,32'h1234,0,12'h0,32'h0,0,0,32'h0,wb(0,0,0,0),
                    0,1,0,0,32'h0,4'd0,0,32'h0};
        vecs[1] = '{1,1,5'd0,32'h5555,0,12'h0,32'h0,0,0,32'h0,wb(0,0,0,0),
                    0,0,0,0,32'h0,4'd0,0,32'h0};
        vecs[2] = '{1,1,5'd3,32'h77,1,12'h305,32'h9,0,0,32'h0,wb(0,1,4'd2,32'h80),
                    1,0,0,1,32'h80,4'd2,1,32'h100};
        vecs[3] = '{1,1,5'd7,32'hbeef,0,12'h0,32'h0,0,0,32'h2000,wb(1,0,0,0),
                    1,1,0,0,32'h0,4'd0,1,32'h2000};
        vecs[4] = '{1,0,5'd1,32'h0,1,12'h341,32'h5,0,1,32'h10,wb(0,0,0,0),
                    1,0,1,0,32'h0,4'd0,1,32'h300};
        vecs[5] = '{0,1,5'd4,32'h1,1,12'h1,32'h1,0,1,32'h40,wb(1,1,4'd3,32'h44),
                    0,0,0,0,32'h0,4'd0,0,32'h0};
        vecs[6] = '{1,1,5'd6,32'h6,0,12'h0,32'h0,0,0,32'h3000,wb(1,1,4'd11,32'h1c),
                    1,0,0,1,32'h1c,4'd11,1,32'h100};
        vecs[7] = '{1,0,5'd0,32'h0,0,12'h0,32'h0,0,1,32'h4000,wb(1,0,0,0),
                    1,0,0,0,32'h0,4'd0,1,32'h300};
        vecs[8] = '{1,0,5'd0,32'h0,1,12'h300,32'haa,0,0,32'h0,wb(0,0,0,0),
                    0,0,1,0,32'h0,4'd0,0,32'h0};
        vecs[9] = '{1,0,5'd12,32'hcafe,0,12'h0,32'h0,0,0,32'h0,wb(0,0,0,0),
                    0,0,0,0,32'h0,4'd0,0,32'h0};

        // Reset with a busy ROB head: everything quiet except commit_valid
        idle();
        rst_n = 0;
        commit_ready = 1; commit_rd_need = 1; commit_rd_idx = 5'd5; commit_rd_data = 32'h1234;
        commit_info = wb(1'b1, 1'b1, 4'd2, 32'h80);
        #1;
        chk("rst_commit_valid", commit_valid, 1);
        chk("rst_rf_wen", rf_wen, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_flush", flush, 0);
        chk("rst_trap", trap_valid, 0);
        chk("rst_redir", redirect_valid, 0);
        chk("rst_inv_req", icache_inv_req, 0);
        @(negedge clk);
        rst_n = 1;
`ifdef HICORE_COMMIT_INSTRET_EN
        exp_instret = 0;
        #1;
        chk("rst_instret", instret, 0);
`endif

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            idle();
            commit_ready = vecs[i].ready;
            commit_rd_need = vecs[i].rd_need; commit_rd_idx = vecs[i].rd_idx;
            commit_rd_data = vecs[i].rd_data;
            commit_csr_need = vecs[i].csr_need; commit_csr_idx = vecs[i].csr_idx;
            commit_csr_data = vecs[i].csr_data;
            commit_fence_i_op = vecs[i].fence; commit_mret_op = vecs[i].mret;
            commit_next_pc = vecs[i].next_pc; commit_info = vecs[i].info;
            #1;
            chk($sformatf("v%0d_commit_valid", i), commit_valid, 1);
            chk($sformatf("v%0d_flush", i), flush, vecs[i].e_flush);
            chk($sformatf("v%0d_rf_wen", i), rf_wen, vecs[i].e_rf_wen);
            if (vecs[i].e_rf_wen) begin
                chk($sformatf("v%0d_rf_waddr", i), rf_waddr, vecs[i].rd_idx);
                chk($sformatf("v%0d_rf_wdata", i), rf_wdata, vecs[i].rd_data);
            end
            chk($sformatf("v%0d_csr_wen", i), csr_wen, vecs[i].e_csr_wen);
            if (vecs[i].e_csr_wen) begin
                chk($sformatf("v%0d_csr_waddr", i), csr_waddr, vecs[i].csr_idx);
                chk($sformatf("v%0d_csr_wdata", i), csr_wdata, vecs[i].csr_data);
            end
            chk($sformatf("v%0d_trap", i), trap_valid, vecs[i].e_trap);
            chk($sformatf("v%0d_trap_epc", i), trap_epc, vecs[i].e_trap_epc);
            chk($sformatf("v%0d_trap_cause", i), trap_cause, vecs[i].e_trap_cause);
            chk($sformatf("v%0d_redir", i), redirect_valid, vecs[i].e_redir);
            if (vecs[i].e_redir)
                chk($sformatf("v%0d_redir_pc", i), redirect_pc, vecs[i].e_redir_pc);
`ifdef HICORE_COMMIT_INSTRET_EN
            if (vecs[i].ready && !vecs[i].info[WB_EXC]) exp_instret++;
`endif
        end
        @(negedge clk);
        idle();
`ifdef HICORE_COMMIT_INSTRET_EN
        #1;
        chk("vec_instret", instret, exp_instret);
`endif

        // Ack while in RUN must not move the FSM
        @(negedge clk);
        icache_inv_ack = 1;
        @(negedge clk);
        icache_inv_ack = 0;
        #1;
        chk("stray_ack_commit_valid", commit_valid, 1);
        chk("stray_ack_redir", redirect_valid, 0);

        fence_seq(32'h44, 3);
        fence_seq(32'h88, 1);
`ifdef HICORE_COMMIT_INSTRET_EN
        chk("fence_instret", instret, exp_instret);
`endif

        // Async reset in the middle of FENCEI_WAIT
        @(negedge clk);
        commit_ready = 1; commit_fence_i_op = 1; commit_next_pc = 32'hc0;
        @(negedge clk);
        idle();
        commit_ready = 1; commit_rd_need = 1; commit_rd_idx = 5'd5;
        #1;
        chk("pre_rst_inv_req", icache_inv_req, 1);
        #2;
        rst_n = 0;
        #1;
        chk("mid_rst_inv_req", icache_inv_req, 0);
        chk("mid_rst_commit_valid", commit_valid, 1);
        chk("mid_rst_rf_wen", rf_wen, 0);
        chk("mid_rst_flush", flush, 0);
        @(negedge clk);
        idle();
        rst_n = 1;
        @(negedge clk);
        #1;
        chk("post_rst_commit_valid", commit_valid, 1);
        chk("post_rst_inv_req", icache_inv_req, 0);
        chk("post_rst_redir", redirect_valid, 0);
`ifdef HICORE_COMMIT_INSTRET_EN
        chk("post_rst_instret", instret, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
